// File: rtl/ram_port_pkg.sv
// Shared definitions for the ISA-side RAM port units: handshake state encoding,
// bus widths and the wait-counter width that bounds LATENCY (1..15).
package ram_port_pkg;

    localparam int unsigned LAT_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned XADDR_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACK    = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } ram_state_e;

    // True when any address bit above the memory's word-address range is set.
    function automatic logic addr_out_of_range(input logic [XADDR_W-1:0] addr,
                                               input int unsigned        width);
        logic hi_set;
        hi_set = ((addr >> width) != {XADDR_W{1'b0}});
        return (width < XADDR_W) && hi_set;
    endfunction

endpackage

// File: rtl/ram_port.sv
// Four-phase txs/txe handshake from the ISA unit to a fixed-latency memory: one mem_en per request,
// completion LATENCY+1 cycles after mem_en; the ISA unit is held off (txe low) until the access is done.
module ram_port
    import ram_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ram_txs,
    input  logic                  ram_we,
    input  logic [XADDR_W-1:0]    ram_addr,
    input  logic [DATA_W-1:0]     ram_wd,
    output logic                  ram_txe,
    output logic [DATA_W-1:0]     ram_rd,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd,
    output logic                  ram_oob
);

    localparam logic [LAT_W-1:0] LAT_VAL = LAT_W'(LATENCY);
    localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

    ram_state_e            state_q,    state_d;
    logic [LAT_W-1:0]      cnt_q,      cnt_d;
    logic                  req_we_q,   req_we_d;
    logic                  req_oob_q,  req_oob_d;
    logic                  ram_txe_q,  ram_txe_d;
    logic [DATA_W-1:0]     ram_rd_q,   ram_rd_d;
    logic                  mem_en_q,   mem_en_d;
    logic                  mem_we_q,   mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wd_q,   mem_wd_d;
    logic                  ram_oob_q,  ram_oob_d;
    logic                  req_is_oob;

    assign req_is_oob = addr_out_of_range(ram_addr, ADDR_WIDTH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_we_d   = req_we_q;
        req_oob_d  = req_oob_q;
        ram_rd_d   = ram_rd_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        ram_oob_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!ram_txs) begin
                    state_d = ST_ACK;
                end
            end
            // Request fields are captured only on the txs release edge; the
            // ACCESS-cycle memory strobes are registered from that same edge.
            ST_ACK: begin
                if (ram_txs) begin
                    state_d    = ST_ACCESS;
                    req_we_d   = ram_we;
                    req_oob_d  = req_is_oob;
                    mem_addr_d = ram_addr[ADDR_WIDTH-1:0];
                    mem_wd_d   = ram_wd;
                    mem_en_d   = !req_is_oob;
                    mem_we_d   = ram_we && !req_is_oob;
                    ram_oob_d  = req_is_oob;
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
                cnt_d   = LAT_VAL;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (!req_we_q) begin
                        ram_rd_d = req_oob_q ? '0 : mem_rd;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ram_txe_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_we_q   <= 1'b0;
            req_oob_q  <= 1'b0;
            ram_txe_q  <= 1'b1;
            ram_rd_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            ram_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_we_q   <= req_we_d;
            req_oob_q  <= req_oob_d;
            ram_txe_q  <= ram_txe_d;
            ram_rd_q   <= ram_rd_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            ram_oob_q  <= ram_oob_d;
        end
    end

    assign ram_txe  = ram_txe_q;
    assign ram_rd   = ram_rd_q;
    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign ram_oob  = ram_oob_q;

endmodule
